// File: rtl/rv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package   : rv_pkg                                                 |
// | Purpose   : Shared core-wide sizing constants (datapath width,     |
// |             architectural register count, register index width,   |
// |             default scoreboard pending-counter width).             |
// | Revision  : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
  localparam int CNTW  = 2;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/regfile_sb_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : regfile_sb_cnt                                         |
// | Purpose   : Write-pending scoreboard. One saturating-free counter  |
// |             per architectural register counts in-flight writes;    |
// |             derives issue_ready, source hazard and a sticky        |
// |             underflow error.                                       |
// | Ports     : clk, rst (async, active-high)                          |
// |             rs1_addr/rs2_addr, rs1_used/rs2_used -> hazard         |
// |             issue_valid, issue_rd -> issue_ready                   |
// |             wb_valid, wb_rd       -> count decrement, sb_err       |
// | Config    : RF_BYPASS_EN - when defined, a writeback in the current|
// |             cycle retires its pending write for hazard purposes.   |
// | Revision  : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
module regfile_sb_cnt
  import rv_pkg::*;
#(
  parameter int NREGS = rv_pkg::NREGS,
  parameter int AW    = $clog2(NREGS),
  parameter int CNTW  = rv_pkg::CNTW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          rs1_used,
  input  logic          rs2_used,
  output logic          hazard,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  output logic          sb_err
);

  localparam logic [CNTW-1:0] c_cnt_max = '1;

  logic [CNTW-1:0]  r_cnt [NREGS];
  logic             r_err;

  logic             w_wb_live;
  logic             w_wb_on_issue;
  logic             w_issue_ready;
  logic             w_issue_fire;
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;
  logic [CNTW-1:0]  w_sub1;
  logic [CNTW-1:0]  w_sub2;
  logic             w_pend1;
  logic             w_pend2;

  assign w_wb_live     = wb_valid && (wb_rd != '0);
  assign w_wb_on_issue = w_wb_live && (wb_rd == issue_rd);

  // A full counter can still accept an issue when the same register retires
  // a write this cycle: the increment and decrement cancel.
  assign w_issue_ready = (issue_rd == '0) || (r_cnt[issue_rd] != c_cnt_max) || w_wb_on_issue;
  assign w_issue_fire  = issue_valid && w_issue_ready && (issue_rd != '0);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_issue_fire) w_inc[issue_rd] = 1'b1;
    if (w_wb_live)    w_dec[wb_rd]    = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= '0;
      r_err <= 1'b0;
    end else begin
      // Entry 0 is never touched after reset, so x0 never looks pending.
      for (int r = 1; r < NREGS; r++) begin
        if (w_inc[r] && !w_dec[r]) begin
          r_cnt[r] <= r_cnt[r] + CNTW'(1);
        end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) begin
          r_cnt[r] <= r_cnt[r] - CNTW'(1);
        end
      end
      // Writeback with nothing outstanding: count holds at zero, flag sticks.
      if (w_wb_live && (r_cnt[wb_rd] == '0)) r_err <= 1'b1;
    end
  end

  // Amount of the current writeback credited against each source's count.
`ifdef RF_BYPASS_EN
  assign w_sub1 = CNTW'(w_wb_live && (wb_rd == rs1_addr));
  assign w_sub2 = CNTW'(w_wb_live && (wb_rd == rs2_addr));
`else
  assign w_sub1 = '0;
  assign w_sub2 = '0;
`endif

  // "count > credit" rather than a subtraction so an unmatched writeback at
  // count 0 cannot underflow into a false hazard.
  assign w_pend1 = rs1_used && (rs1_addr != '0) && (r_cnt[rs1_addr] > w_sub1);
  assign w_pend2 = rs2_used && (rs2_addr != '0) && (r_cnt[rs2_addr] > w_sub2);

  assign hazard      = w_pend1 || w_pend2;
  assign issue_ready = w_issue_ready;
  assign sb_err      = r_err;

endmodule : regfile_sb_cnt
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : regfile_sb                                             |
// | Purpose   : Integer register file with write-pending scoreboard.   |
// |             Holds the data array, two combinational read ports and |
// |             the optional WB bypass; scoreboard in regfile_sb_cnt.  |
// | Ports     : clk, rst (async, active-high)                          |
// |             rs1_addr/rs2_addr, rs1_used/rs2_used                   |
// |             rs1_data/rs2_data (comb), hazard                       |
// |             issue_valid, issue_rd, issue_ready                     |
// |             wb_valid, wb_rd, reg_wb, sb_err (sticky)               |
// | Config    : RF_BYPASS_EN - when defined, reads matching the live   |
// |             writeback return reg_wb in the same cycle.             |
// | Revision  : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
module regfile_sb
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NREGS = rv_pkg::NREGS,
  parameter int AW    = $clog2(NREGS),
  parameter int CNTW  = rv_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            hazard,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] reg_wb,
  output logic            sb_err
);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else if (wb_valid && (wb_rd != '0)) begin
      r_regs[wb_rd] <= reg_wb;
    end
  end

  always_comb begin
    rs1_data = r_regs[rs1_addr];
    rs2_data = r_regs[rs2_addr];
`ifdef RF_BYPASS_EN
    if (wb_valid && (wb_rd == rs1_addr)) rs1_data = reg_wb;
    if (wb_valid && (wb_rd == rs2_addr)) rs2_data = reg_wb;
`endif
    // x0 wins over the bypass: a WB to x0 must never become visible.
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

  regfile_sb_cnt #(
    .NREGS (NREGS),
    .AW    (AW),
    .CNTW  (CNTW)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .hazard      (hazard),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .sb_err      (sb_err)
  );

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : tb_regfile_sb                                          |
// | Purpose   : Self-checking bench for regfile_sb: directed scenarios |
// |             followed by randomized traffic, all outputs compared   |
// |             each cycle against a behavioural model.                |
// | Config    : honours RF_BYPASS_EN the same way as the design.       |
// | Revision  : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
module tb_regfile_sb;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXCNT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_used, rs2_used;
  logic [31:0] rs1_data, rs2_data;
  logic        hazard;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] reg_wb;
  logic        sb_err;

  // Reference state
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .hazard      (hazard),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .reg_wb      (reg_wb),
    .sb_err      (sb_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_hit(input int r);
    return wb_valid && (int'(wb_rd) == r) && (r != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && m_hit(int'(a))) return reg_wb;
    return m_regs[a];
  endfunction

  function automatic bit m_pend(input logic [4:0] a);
    int eff;
    eff = m_cnt[a] - ((BYP && m_hit(int'(a))) ? 1 : 0);
    return (a != 0) && (eff > 0);
  endfunction

  function automatic bit m_ready();
    return (issue_rd == 0) || (m_cnt[issue_rd] < MAXCNT) || m_hit(int'(issue_rd));
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'h0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic m_step();
    bit fire;
    int net;
    fire = issue_valid && m_ready() && (issue_rd != 0);
    if (m_hit(int'(wb_rd))) begin
      if (m_cnt[wb_rd] == 0) m_err = 1'b1;
      m_regs[wb_rd] = reg_wb;
    end
    for (int r = 1; r < 32; r++) begin
      net = ((fire && int'(issue_rd) == r) ? 1 : 0) - (m_hit(r) ? 1 : 0);
      m_cnt[r] = (m_cnt[r] + net < 0) ? 0 : m_cnt[r] + net;
    end
  endtask

  task automatic check_outputs();
    bit exp_haz;
    exp_haz = (rs1_used && m_pend(rs1_addr)) || (rs2_used && m_pend(rs2_addr));
    check_val("rs1_data", rs1_data, m_read(rs1_addr));
    check_val("rs2_data", rs2_data, m_read(rs2_addr));
    check_val("hazard", 32'(hazard), 32'(exp_haz));
    check_val("issue_ready", 32'(issue_ready), 32'(m_ready()));
    check_val("sb_err", 32'(sb_err), 32'(m_err));
  endtask

  // One clock: inputs already set just after a falling edge.
  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; reg_wb = 0;
    rs1_used = 0; rs2_used = 0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    issue_valid = 0;
    wb_valid    = 0;
    rst = 1'b1;
    #1;
    check_val("rst_rs1_data", rs1_data, 32'h0);
    check_val("rst_rs2_data", rs2_data, 32'h0);
    check_val("rst_hazard", 32'(hazard), 32'h0);
    check_val("rst_issue_ready", 32'(issue_ready), 32'h1);
    check_val("rst_sb_err", 32'(sb_err), 32'h0);
    m_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    rst = 1'b0;
    rs1_addr = 0; rs2_addr = 0;
    idle();
    @(negedge clk);
    do_reset();

    // Issue x5, then its writeback observed by rs1 in the WB cycle.
    issue_valid = 1; issue_rd = 5; cyc();
    issue_valid = 0;
    wb_valid = 1; wb_rd = 5; reg_wb = 32'hDEADBEEF;
    rs1_addr = 5; rs1_used = 1;
    #1;
    if (BYP) begin
      check_val("t2_byp_data", rs1_data, 32'hDEADBEEF);
      check_val("t2_byp_hazard", 32'(hazard), 32'h0);
    end else begin
      check_val("t2_nobyp_hazard", 32'(hazard), 32'h1);
    end
    cyc();
    wb_valid = 0;
    #1;
    check_val("t2_next_hazard", 32'(hazard), 32'h0);
    check_val("t2_next_data", rs1_data, 32'hDEADBEEF);
    cyc();

    // x0 is inert.
    issue_valid = 1; issue_rd = 0; cyc();
    issue_valid = 0;
    wb_valid = 1; wb_rd = 0; reg_wb = 32'h1234; rs2_addr = 0; rs2_used = 1;
    #1;
    check_val("t3_x0_read", rs2_data, 32'h0);
    check_val("t3_x0_ready", 32'(issue_ready), 32'h1);
    cyc();
    wb_valid = 0;
    #1;
    check_val("t3_x0_err", 32'(sb_err), 32'h0);
    cyc();

    // Saturate x7.
    issue_valid = 1; issue_rd = 7;
    for (int i = 0; i < 3; i++) cyc();
    issue_valid = 0; rs2_addr = 7; rs2_used = 1;
    #1;
    check_val("t4_full_ready", 32'(issue_ready), 32'h0);
    check_val("t4_full_hazard", 32'(hazard), 32'h1);
    cyc();
    issue_valid = 1; cyc();       // dropped: not ready
    issue_valid = 0;
    wb_valid = 1; wb_rd = 7; reg_wb = 32'h77;
    #1;
    check_val("t4_wb_ready", 32'(issue_ready), 32'h1);
    cyc();
    wb_valid = 0; cyc();

    // Mid-run reset with x7 still pending and x5 written.
    rs1_addr = 5; rs1_used = 1; issue_rd = 7;
    do_reset();
    cyc();

    // Simultaneous issue and WB on x3 with one outstanding.
    idle();
    issue_valid = 1; issue_rd = 3; cyc();
    wb_valid = 1; wb_rd = 3; reg_wb = 32'h33;
    rs1_addr = 3; rs1_used = 1;
    cyc();
    idle(); rs1_used = 1;
    #1;
    check_val("t5_hazard", 32'(hazard), 32'h1);
    cyc();

    // Unmatched writeback to x9.
    idle();
    wb_valid = 1; wb_rd = 9; reg_wb = 32'h55; cyc();
    wb_valid = 0; rs1_addr = 9;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_val("t6_err_sticky", 32'(sb_err), 32'h1);
      check_val("t6_data", rs1_data, 32'h55);
      cyc();
    end
    do_reset();
    #1;
    check_val("t6_err_cleared", 32'(sb_err), 32'h0);
    cyc();

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 600; n++) begin
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      rs1_used    = 1'($urandom_range(0, 1));
      rs2_used    = 1'($urandom_range(0, 1));
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      reg_wb      = $urandom;
      wb_valid    = 0;
      wb_rd       = 0;
      if ($urandom_range(0, 99) < 4) begin
        wb_valid = 1;
        wb_rd    = 5'($urandom_range(0, 7));
      end else if ($urandom_range(0, 99) < 55) begin
        for (int t = 0; t < 8; t++) begin
          r = $urandom_range(1, 7);
          if (!wb_valid && m_cnt[r] > 0) begin
            wb_valid = 1;
            wb_rd    = 5'(r);
          end
        end
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_regfile_sb
`default_nettype wire
